// File: rtl/pwm_duty_decoder_pkg.sv
// rtl/pwm_duty_decoder_pkg.sv - shared FSM encoding and limit helpers for the PWM duty decoder
package pwm_duty_decoder_pkg;

    localparam logic [1:0] ST_SEEK = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    // Saturation/timeout limits depend on the instance widths, so they are computed per instance.
    function automatic int timeout_cnt(input int cnt_bitwidth);
        return (1 << cnt_bitwidth) - 1;
    endfunction

    function automatic int duty_max(input int adc_bitwidth);
        return (1 << adc_bitwidth) - 1;
    endfunction

endpackage

// File: rtl/pwm_duty_decoder_div.sv
// rtl/pwm_duty_decoder_div.sv - restoring divider computing (high << ADC_BITWIDTH) / period
module pwm_duty_div
    import pwm_duty_decoder_pkg::*;
#(
    parameter int ADC_BITWIDTH = 4,
    parameter int CNT_BITWIDTH = 5
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    clk_en_i,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [CNT_BITWIDTH-1:0] num_i,
    input  logic [CNT_BITWIDTH-1:0] den_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [ADC_BITWIDTH-1:0] quot_o
);

    localparam int                      STEP_W    = $clog2(ADC_BITWIDTH + 1);
    localparam logic [STEP_W-1:0]       LAST_STEP = STEP_W'(ADC_BITWIDTH);
    localparam logic [ADC_BITWIDTH-1:0] DUTY_MAX  = ADC_BITWIDTH'(duty_max(ADC_BITWIDTH));

    logic                    r_busy;
    logic                    r_sat;
    logic [STEP_W-1:0]       r_step;
    logic [CNT_BITWIDTH-1:0] r_rem;
    logic [CNT_BITWIDTH-1:0] r_den;
    logic [ADC_BITWIDTH-1:0] r_quot;

    logic [CNT_BITWIDTH:0]   w_shift;
    logic                    w_ge;
    logic                    w_iter;

    // The numerator's low ADC_BITWIDTH bits are zero, so the remainder starts as high and shifts in zeros.
    assign w_shift = {r_rem, 1'b0};
    assign w_ge    = w_shift >= {1'b0, r_den};
    assign w_iter  = r_busy && (r_step != LAST_STEP);
    assign done_o  = r_busy && (r_step == LAST_STEP);
    assign busy_o  = r_busy;
    assign quot_o  = r_sat ? DUTY_MAX : r_quot;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_busy <= 1'b0;
            r_sat  <= 1'b0;
            r_step <= '0;
            r_rem  <= '0;
            r_den  <= '0;
            r_quot <= '0;
        end else if (clk_en_i) begin
            if (abort_i || done_o) begin
                r_busy <= 1'b0;
            end else if (w_iter) begin
                r_rem  <= w_ge ? (w_shift[CNT_BITWIDTH-1:0] - r_den) : w_shift[CNT_BITWIDTH-1:0];
                r_quot <= {r_quot[ADC_BITWIDTH-2:0], w_ge};
                r_step <= r_step + 1'b1;
            end else if (start_i) begin
                // high >= period means a quotient of 2^ADC_BITWIDTH or more: saturate.
                r_busy <= 1'b1;
                r_sat  <= num_i >= den_i;
                r_rem  <= num_i;
                r_den  <= den_i;
                r_quot <= '0;
                r_step <= '0;
            end
        end
    end

endmodule

// File: rtl/pwm_duty_decoder.sv
// rtl/pwm_duty_decoder.sv - PWM receiver measuring high time and period and producing a duty value
module pwm_duty_decoder
    import pwm_duty_decoder_pkg::*;
#(
    parameter int ADC_BITWIDTH = 4,
    parameter int CNT_BITWIDTH = 5
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    clk_en_i,
    input  logic                    pwm_i,
    output logic [ADC_BITWIDTH-1:0] duty_o,
    output logic [CNT_BITWIDTH-1:0] high_o,
    output logic [CNT_BITWIDTH-1:0] period_o,
    output logic                    valid_o,
    output logic                    timeout_o,
    output logic                    overrun_o
);

    localparam logic [CNT_BITWIDTH-1:0] TIMEOUT_CNT = CNT_BITWIDTH'(timeout_cnt(CNT_BITWIDTH));
    localparam logic [ADC_BITWIDTH-1:0] DUTY_MAX    = ADC_BITWIDTH'(duty_max(ADC_BITWIDTH));

    logic                    r_sync1;
    logic                    r_sync2;
    logic                    r_prev;
    logic [1:0]              r_state;
    logic [CNT_BITWIDTH-1:0] r_high_cnt;
    logic [CNT_BITWIDTH-1:0] r_per_cnt;
    logic [CNT_BITWIDTH-1:0] r_high_sh;
    logic [CNT_BITWIDTH-1:0] r_per_sh;
    logic [CNT_BITWIDTH-1:0] r_high;
    logic [CNT_BITWIDTH-1:0] r_period;
    logic [ADC_BITWIDTH-1:0] r_duty;
    logic                    r_valid;
    logic                    r_timeout;
    logic                    r_overrun;

    logic                    w_rise;
    logic                    w_fall;
    logic                    w_timeout;
    logic                    w_start;
    logic                    w_div_busy;
    logic                    w_div_done;
    logic [ADC_BITWIDTH-1:0] w_quot;
    logic [CNT_BITWIDTH-1:0] w_high_inc;
    logic [CNT_BITWIDTH-1:0] w_per_inc;

    assign w_rise     = r_sync2 & ~r_prev;
    assign w_fall     = ~r_sync2 & r_prev;
    assign w_high_inc = (r_high_cnt == '1) ? r_high_cnt : r_high_cnt + 1'b1;
    assign w_per_inc  = (r_per_cnt == '1) ? r_per_cnt : r_per_cnt + 1'b1;

    // In SEEK the timeout fires only once per stuck episode; r_timeout stays set until a real result.
    always_comb begin
        w_timeout = 1'b0;
        case (r_state)
            ST_SEEK:         w_timeout = !w_rise && (r_per_cnt == TIMEOUT_CNT) && !r_timeout;
            ST_HIGH, ST_LOW: w_timeout = (r_per_cnt == TIMEOUT_CNT);
            default:         w_timeout = 1'b0;
        endcase
    end

    assign w_start = (r_state == ST_LOW) && w_rise && !w_timeout && !w_div_busy;

    pwm_duty_div #(
        .ADC_BITWIDTH(ADC_BITWIDTH),
        .CNT_BITWIDTH(CNT_BITWIDTH)
    ) u_div (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .clk_en_i (clk_en_i),
        .start_i  (w_start),
        .abort_i  (w_timeout),
        .num_i    (r_high_cnt),
        .den_i    (r_per_cnt),
        .busy_o   (w_div_busy),
        .done_o   (w_div_done),
        .quot_o   (w_quot)
    );

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_prev     <= 1'b0;
            r_state    <= ST_SEEK;
            r_high_cnt <= '0;
            r_per_cnt  <= '0;
            r_high_sh  <= '0;
            r_per_sh   <= '0;
            r_high     <= '0;
            r_period   <= '0;
            r_duty     <= '0;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (clk_en_i) begin
            r_sync1   <= pwm_i;
            r_sync2   <= r_sync1;
            r_prev    <= r_sync2;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;

            if (w_div_done) begin
                r_duty    <= w_quot;
                r_high    <= r_high_sh;
                r_period  <= r_per_sh;
                r_valid   <= 1'b1;
                r_timeout <= 1'b0;
            end

            // A timeout overrides any divider result completing in the same cycle.
            if (w_timeout) begin
                r_duty     <= r_sync2 ? DUTY_MAX : '0;
                r_high     <= '0;
                r_period   <= '0;
                r_valid    <= 1'b1;
                r_timeout  <= 1'b1;
                r_high_cnt <= '0;
                r_per_cnt  <= '0;
                r_state    <= ST_SEEK;
            end else begin
                case (r_state)
                    ST_SEEK: begin
                        if (w_rise) begin
                            r_high_cnt <= CNT_BITWIDTH'(1);
                            r_per_cnt  <= CNT_BITWIDTH'(1);
                            r_state    <= ST_HIGH;
                        end else begin
                            r_per_cnt <= w_per_inc;
                        end
                    end
                    ST_HIGH: begin
                        r_per_cnt <= w_per_inc;
                        if (w_fall) begin
                            r_state <= ST_LOW;
                        end else begin
                            r_high_cnt <= w_high_inc;
                        end
                    end
                    ST_LOW: begin
                        if (w_rise) begin
                            if (w_div_busy) begin
                                r_overrun <= 1'b1;
                            end else begin
                                r_high_sh <= r_high_cnt;
                                r_per_sh  <= r_per_cnt;
                            end
                            r_high_cnt <= CNT_BITWIDTH'(1);
                            r_per_cnt  <= CNT_BITWIDTH'(1);
                            r_state    <= ST_HIGH;
                        end else begin
                            r_per_cnt <= w_per_inc;
                        end
                    end
                    default: r_state <= ST_SEEK;
                endcase
            end
        end else begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign duty_o    = r_duty;
    assign high_o    = r_high;
    assign period_o  = r_period;
    assign valid_o   = r_valid;
    assign timeout_o = r_timeout;
    assign overrun_o = r_overrun;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb/tb_pwm_duty_decoder.sv - timestamp-based reference model and randomized stimulus for pwm_duty_decoder
module tb_pwm_duty_decoder;

    localparam int TO   = 31;
    localparam int DMAX = 15;
    localparam int LAT  = 5;

    logic       clk = 1'b0;
    logic       rstn_i = 1'b0;
    logic       clk_en_i = 1'b0;
    logic       pwm_i = 1'b0;
    logic [3:0] duty_o;
    logic [4:0] high_o;
    logic [4:0] period_o;
    logic       valid_o;
    logic       timeout_o;
    logic       overrun_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_valid = 0;
    int n_ovr = 0;

    // Model state: sampled line history since reset plus timestamps of edges and the pending job.
    int pw[$];
    bit trk;
    int t_rise, t_fall, seek_cnt;
    bit job_act;
    int job_done, job_duty, job_hi, job_per;
    int e_duty, e_high, e_per;
    bit e_valid, e_to, e_ovr;
    int m_valid = 0;
    int m_ovr = 0;

    pwm_duty_decoder #(.ADC_BITWIDTH(4), .CNT_BITWIDTH(5)) dut (
        .clk_i     (clk),
        .rstn_i    (rstn_i),
        .clk_en_i  (clk_en_i),
        .pwm_i     (pwm_i),
        .duty_o    (duty_o),
        .high_o    (high_o),
        .period_o  (period_o),
        .valid_o   (valid_o),
        .timeout_o (timeout_o),
        .overrun_o (overrun_o)
    );

    always #5 clk = ~clk;

    function automatic bit lvl_at(input int j);
        return (j >= 2) ? pw[j-2][0] : 1'b0;
    endfunction

    task automatic do_timeout(input bit lv);
        job_act  = 0;
        e_duty   = lv ? DMAX : 0;
        e_high   = 0;
        e_per    = 0;
        e_valid  = 1;
        e_to     = 1;
        trk      = 0;
        seek_cnt = 0;
    endtask

    task automatic model_step(input bit p, input bit en, input bit rn);
        int k;
        bit lv, lp, rise, fall, busy, was_to;
        if (!rn) begin
            pw.delete();
            trk = 0; seek_cnt = 0; job_act = 0;
            e_duty = 0; e_high = 0; e_per = 0; e_valid = 0; e_to = 0; e_ovr = 0;
            return;
        end
        e_valid = 0;
        e_ovr = 0;
        if (!en) return;
        pw.push_back(int'(p));
        k = pw.size() - 1;
        lv = lvl_at(k);
        lp = lvl_at(k - 1);
        rise = lv && !lp;
        fall = !lv && lp;
        busy = job_act;
        was_to = e_to;
        if (job_act && k == job_done) begin
            e_duty = job_duty; e_high = job_hi; e_per = job_per;
            e_valid = 1; e_to = 0; job_act = 0;
        end
        if (trk) begin
            if (k - t_rise == TO) begin
                do_timeout(lv);
            end else if (rise) begin
                if (busy) begin
                    e_ovr = 1;
                end else begin
                    job_act  = 1;
                    job_done = k + LAT;
                    job_hi   = t_fall - t_rise;
                    job_per  = k - t_rise;
                    job_duty = (job_hi * 16) / job_per;
                    if (job_duty > DMAX) job_duty = DMAX;
                end
                t_rise = k;
            end else if (fall) begin
                t_fall = k;
            end
        end else begin
            if (rise) begin
                trk = 1;
                t_rise = k;
            end else if (seek_cnt == TO && !was_to) begin
                do_timeout(lv);
            end else if (seek_cnt < TO) begin
                seek_cnt++;
            end
        end
        if (e_valid) m_valid++;
        if (e_ovr) m_ovr++;
    endtask

    task automatic step(input bit p, input bit en, input bit rn);
        @(negedge clk);
        pwm_i = p;
        clk_en_i = en;
        rstn_i = rn;
        @(posedge clk);
        #1;
        model_step(p, en, rn);
        cyc++;
        if (valid_o) n_valid++;
        if (overrun_o) n_ovr++;
        checks++;
        if ({duty_o, high_o, period_o, valid_o, timeout_o, overrun_o} !==
            {4'(e_duty), 5'(e_high), 5'(e_per), e_valid, e_to, e_ovr}) begin
            errors++;
            $display("FAIL cycle %0d: got duty=%0d high=%0d per=%0d v=%0b to=%0b ov=%0b, want duty=%0d high=%0d per=%0d v=%0b to=%0b ov=%0b",
                     cyc, duty_o, high_o, period_o, valid_o, timeout_o, overrun_o,
                     e_duty, e_high, e_per, e_valid, e_to, e_ovr);
        end
    endtask

    task automatic lit(input string name, input int dut_v, input int mdl_v, input int want);
        checks++;
        if (dut_v != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, dut_v, want);
        end
        checks++;
        if (mdl_v != want) begin
            errors++;
            $display("FAIL %s_model: got %0d want %0d", name, mdl_v, want);
        end
    endtask

    task automatic clr_counts();
        n_valid = 0; m_valid = 0; n_ovr = 0; m_ovr = 0;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic hold(input bit v, input int n);
        for (int i = 0; i < n; i++) step(v, 1'b1, 1'b1);
    endtask

    // en_mode 0: always enabled, 1: strict 1-in-2, 2: random gaps; the line wanders on disabled cycles.
    task automatic wave(input int per, input int hi, input int nper, input int en_mode);
        for (int p = 0; p < nper; p++) begin
            for (int i = 0; i < per; i++) begin
                if (en_mode == 1 || (en_mode == 2 && $urandom_range(0, 3) == 0))
                    step(1'($urandom_range(0, 1)), 1'b0, 1'b1);
                step(i < hi, 1'b1, 1'b1);
            end
        end
    endtask

    initial begin
        do_reset();
        lit("rst_duty", int'(duty_o), e_duty, 0);
        lit("rst_period", int'(period_o), e_per, 0);
        lit("rst_timeout", int'(timeout_o), int'(e_to), 0);

        clr_counts();
        wave(18, 9, 4, 0);
        lit("s1_high", int'(high_o), e_high, 9);
        lit("s1_period", int'(period_o), e_per, 18);
        lit("s1_duty", int'(duty_o), e_duty, 8);
        lit("s1_nvalid", n_valid, m_valid, 3);

        wave(18, 3, 3, 0);
        lit("lo_duty", int'(duty_o), e_duty, 2);
        wave(18, 17, 3, 0);
        lit("hi_duty", int'(duty_o), e_duty, 15);
        lit("hi_high", int'(high_o), e_high, 17);

        clr_counts();
        hold(1'b0, 80);
        lit("to0_timeout", int'(timeout_o), int'(e_to), 1);
        lit("to0_duty", int'(duty_o), e_duty, 0);
        lit("to0_nvalid", n_valid, m_valid, 1);
        clr_counts();
        hold(1'b1, 80);
        lit("to1_duty", int'(duty_o), e_duty, 15);
        lit("to1_nvalid", n_valid, m_valid, 1);
        wave(18, 9, 3, 0);
        lit("rec_timeout", int'(timeout_o), int'(e_to), 0);
        lit("rec_duty", int'(duty_o), e_duty, 8);

        clr_counts();
        wave(4, 2, 12, 0);
        lit("ov_period", int'(period_o), e_per, 4);
        lit("ov_duty", int'(duty_o), e_duty, 8);
        lit("ov_count", n_ovr, m_ovr, 6);
        lit("ov_nvalid", n_valid, m_valid, 6);

        do_reset();
        wave(18, 9, 1, 0);
        hold(1'b1, 5);
        step(1'b1, 1'b1, 1'b0);
        lit("mid_duty", int'(duty_o), e_duty, 0);
        lit("mid_high", int'(high_o), e_high, 0);
        lit("mid_valid", int'(valid_o), int'(e_valid), 0);
        clr_counts();
        wave(18, 9, 3, 0);
        lit("mid_nvalid", n_valid, m_valid, 2);
        lit("mid_after_duty", int'(duty_o), e_duty, 8);

        do_reset();
        clr_counts();
        wave(18, 9, 4, 1);
        lit("en_period", int'(period_o), e_per, 18);
        lit("en_duty", int'(duty_o), e_duty, 8);
        lit("en_nvalid", n_valid, m_valid, 3);

        for (int r = 0; r < 60; r++) begin
            int sel, per, hi;
            sel = $urandom_range(0, 11);
            if (sel == 0) begin
                hold(1'($urandom_range(0, 1)), $urandom_range(35, 45));
            end else if (sel == 1) begin
                per = $urandom_range(2, 5);
                wave(per, $urandom_range(1, per - 1), $urandom_range(3, 6), $urandom_range(0, 2));
            end else if (sel == 2) begin
                step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
            end else begin
                per = $urandom_range(6, 28);
                hi = $urandom_range(1, per - 1);
                wave(per, hi, $urandom_range(1, 4), $urandom_range(0, 2));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
